// File: rtl/guess_checker_if.sv
// Handshake/result bundle between the guess checker and its environment.
// Names carry the direction as seen from the checker (i_ into it, o_ out of it).
interface guess_checker_if;
   logic        i_new_game;
   logic        i_submit_guess;
   logic [16:0] i_guess;
   logic [16:0] i_nvalue;
   logic        o_higher;
   logic        o_lower;
   logic        o_correct;
   logic        o_invalid;
   logic        o_result_valid;
   logic        o_game_over;
   logic [7:0]  o_tries;
   logic        o_playing;

   modport slave (
      input  i_new_game, i_submit_guess, i_guess, i_nvalue,
      output o_higher, o_lower, o_correct, o_invalid,
             o_result_valid, o_game_over, o_tries, o_playing
   );

   modport master (
      output i_new_game, i_submit_guess, i_guess, i_nvalue,
      input  o_higher, o_lower, o_correct, o_invalid,
             o_result_valid, o_game_over, o_tries, o_playing
   );
endinterface

// File: rtl/guess_checker.sv
// Number-guessing game core: latches a BCD target, judges debounced-edge guesses
// against it, counts attempts in BCD and ends the game on a win or attempt limit.
module guess_checker #(
   parameter int MAX_TRIES = 10
) (
   input logic           i_clk,
   input logic           i_reset,
   guess_checker_if.slave bus
);

   localparam logic [3:0] MAX_TENS  = 4'(MAX_TRIES / 10);
   localparam logic [3:0] MAX_UNITS = 4'(MAX_TRIES % 10);
   localparam logic [7:0] MAX_BCD   = {MAX_TENS, MAX_UNITS};

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PLAY  = 3'd1,
      ST_CHECK = 3'd2,
      ST_WIN   = 3'd3,
      ST_LOSE  = 3'd4
   } state_t;

   function automatic logic bcd_ok(input logic [15:0] v);
      return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) &&
             (v[11:8] <= 4'd9) && (v[15:12] <= 4'd9);
   endfunction

   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      if (v[3:0] == 4'd9) begin
         return {v[7:4] + 4'd1, 4'd0};
      end else begin
         return {v[7:4], v[3:0] + 4'd1};
      end
   endfunction

   state_t      r_state;
   logic        r_sync1, r_sync2, r_sub_d;
   logic [16:0] r_target, r_guess;
   logic        r_higher, r_lower, r_correct, r_invalid;
   logic        r_result_valid, r_game_over, r_playing;
   logic [7:0]  r_tries;

   state_t      w_state_nxt;
   logic [16:0] w_target_nxt, w_guess_nxt;
   logic        w_higher_nxt, w_lower_nxt, w_correct_nxt, w_invalid_nxt;
   logic        w_result_valid_nxt, w_game_over_nxt, w_playing_nxt;
   logic [7:0]  w_tries_nxt, w_tries_inc;
   logic        w_press, w_guess_ok, w_below, w_above;

   // Falling edge of the synchronised button; held presses count once.
   assign w_press     = ~r_sync2 & r_sub_d;
   assign w_guess_ok  = bcd_ok(r_guess[15:0]);
   assign w_below     = r_guess < r_target;
   assign w_above     = r_guess > r_target;
   assign w_tries_inc = bcd_inc(r_tries);
   assign w_playing_nxt = (w_state_nxt == ST_PLAY) || (w_state_nxt == ST_CHECK);

   // Two-stage synchroniser plus edge-detect register for the raw button.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_sub_d <= 1'b1;
      end else begin
         r_sync1 <= bus.i_submit_guess;
         r_sync2 <= r_sync1;
         r_sub_d <= r_sync2;
      end
   end

   // State and game registers.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state        <= ST_IDLE;
         r_target       <= 17'h10000;
         r_guess        <= 17'h00000;
         r_higher       <= 1'b0;
         r_lower        <= 1'b0;
         r_correct      <= 1'b0;
         r_invalid      <= 1'b0;
         r_result_valid <= 1'b0;
         r_game_over    <= 1'b0;
         r_tries        <= 8'h00;
         r_playing      <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_target       <= w_target_nxt;
         r_guess        <= w_guess_nxt;
         r_higher       <= w_higher_nxt;
         r_lower        <= w_lower_nxt;
         r_correct      <= w_correct_nxt;
         r_invalid      <= w_invalid_nxt;
         r_result_valid <= w_result_valid_nxt;
         r_game_over    <= w_game_over_nxt;
         r_tries        <= w_tries_nxt;
         r_playing      <= w_playing_nxt;
      end
   end

   // Next-state and next-output logic; new_game overrides everything, including a same-cycle press.
   always_comb begin
      w_state_nxt        = r_state;
      w_target_nxt       = r_target;
      w_guess_nxt        = r_guess;
      w_higher_nxt       = r_higher;
      w_lower_nxt        = r_lower;
      w_correct_nxt      = r_correct;
      w_invalid_nxt      = r_invalid;
      w_result_valid_nxt = 1'b0;
      w_game_over_nxt    = r_game_over;
      w_tries_nxt        = r_tries;
      if (bus.i_new_game) begin
         w_state_nxt     = ST_PLAY;
         w_target_nxt    = bus.i_nvalue;
         w_higher_nxt    = 1'b0;
         w_lower_nxt     = 1'b0;
         w_correct_nxt   = 1'b0;
         w_invalid_nxt   = 1'b0;
         w_game_over_nxt = 1'b0;
         w_tries_nxt     = 8'h00;
      end else begin
         case (r_state)
            ST_PLAY: begin
               if (w_press) begin
                  w_guess_nxt = bus.i_guess;
                  w_state_nxt = ST_CHECK;
               end else begin
                  w_state_nxt = ST_PLAY;
               end
            end
            ST_CHECK: begin
               w_result_valid_nxt = 1'b1;
               if (!w_guess_ok) begin
                  w_invalid_nxt = 1'b1;
                  w_higher_nxt  = 1'b0;
                  w_lower_nxt   = 1'b0;
                  w_correct_nxt = 1'b0;
                  w_state_nxt   = ST_PLAY;
               end else begin
                  w_invalid_nxt = 1'b0;
                  w_tries_nxt   = w_tries_inc;
                  w_higher_nxt  = w_below;
                  w_lower_nxt   = w_above;
                  w_correct_nxt = ~w_below & ~w_above;
                  if (~w_below & ~w_above) begin
                     w_state_nxt = ST_WIN;
                  end else if (w_tries_inc == MAX_BCD) begin
                     w_state_nxt     = ST_LOSE;
                     w_game_over_nxt = 1'b1;
                  end else begin
                     w_state_nxt = ST_PLAY;
                  end
               end
            end
            ST_IDLE, ST_WIN, ST_LOSE: begin
               w_state_nxt = r_state;
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   assign bus.o_higher       = r_higher;
   assign bus.o_lower        = r_lower;
   assign bus.o_correct      = r_correct;
   assign bus.o_invalid      = r_invalid;
   assign bus.o_result_valid = r_result_valid;
   assign bus.o_game_over    = r_game_over;
   assign bus.o_tries        = r_tries;
   assign bus.o_playing      = r_playing;

endmodule

// File: tb/tb_guess_checker.sv
// Bench for guess_checker: two instances (limit 10 and limit 3) share one stimulus
// stream and are checked every cycle against a decimal-arithmetic game model.
module tb_guess_checker;

   localparam int P_IDLE = 0, P_PLAY = 1, P_CHECK = 2, P_WIN = 3, P_LOSE = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic chk_en = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   rv_cnt [2] = '{0, 0};
   int   rv_snap;

   always #5 clk = ~clk;

   guess_checker_if ifa ();
   guess_checker_if ifb ();

   assign ifb.i_new_game     = ifa.i_new_game;
   assign ifb.i_submit_guess = ifa.i_submit_guess;
   assign ifb.i_guess        = ifa.i_guess;
   assign ifb.i_nvalue       = ifa.i_nvalue;

   guess_checker #(.MAX_TRIES(10)) dut_a (.i_clk(clk), .i_reset(rst), .bus(ifa));
   guess_checker #(.MAX_TRIES(3))  dut_b (.i_clk(clk), .i_reset(rst), .bus(ifb));

   // ---------------- behavioural model ----------------
   int          m_max   [2] = '{10, 3};
   int          m_phase [2];
   int          m_target[2];
   int          m_tries [2];
   logic [16:0] m_guess [2];
   logic        m_hi[2], m_lo[2], m_co[2], m_inv[2], m_rv[2], m_go[2];
   logic        s1, s2, sd;

   function automatic int bcd2int(input logic [16:0] v);
      return int'(v[16]) * 10000 + int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 +
             int'(v[7:4]) * 10 + int'(v[3:0]);
   endfunction

   function automatic logic has_bad_digit(input logic [16:0] v);
      return (v[15:12] > 4'd9) || (v[11:8] > 4'd9) || (v[7:4] > 4'd9) || (v[3:0] > 4'd9);
   endfunction

   task automatic model_step();
      logic press;
      int   g;
      press = !s2 && sd;
      if (rst) begin
         s1 = 1'b1; s2 = 1'b1; sd = 1'b1;
         for (int k = 0; k < 2; k++) begin
            m_phase[k] = P_IDLE; m_target[k] = 10000; m_tries[k] = 0; m_guess[k] = 17'h0;
            m_hi[k] = 1'b0; m_lo[k] = 1'b0; m_co[k] = 1'b0; m_inv[k] = 1'b0;
            m_rv[k] = 1'b0; m_go[k] = 1'b0;
         end
      end else begin
         sd = s2; s2 = s1; s1 = ifa.i_submit_guess;
         for (int k = 0; k < 2; k++) begin
            m_rv[k] = 1'b0;
            if (ifa.i_new_game) begin
               m_phase[k] = P_PLAY; m_target[k] = bcd2int(ifa.i_nvalue); m_tries[k] = 0;
               m_hi[k] = 1'b0; m_lo[k] = 1'b0; m_co[k] = 1'b0; m_inv[k] = 1'b0; m_go[k] = 1'b0;
            end else if (m_phase[k] == P_PLAY && press) begin
               m_guess[k] = ifa.i_guess;
               m_phase[k] = P_CHECK;
            end else if (m_phase[k] == P_CHECK) begin
               m_rv[k] = 1'b1;
               if (has_bad_digit(m_guess[k])) begin
                  m_inv[k] = 1'b1; m_hi[k] = 1'b0; m_lo[k] = 1'b0; m_co[k] = 1'b0;
                  m_phase[k] = P_PLAY;
               end else begin
                  g = bcd2int(m_guess[k]);
                  m_inv[k] = 1'b0;
                  m_tries[k] = m_tries[k] + 1;
                  m_hi[k] = (g < m_target[k]);
                  m_lo[k] = (g > m_target[k]);
                  m_co[k] = (g == m_target[k]);
                  if (m_co[k]) m_phase[k] = P_WIN;
                  else if (m_tries[k] == m_max[k]) begin
                     m_phase[k] = P_LOSE;
                     m_go[k] = 1'b1;
                  end else m_phase[k] = P_PLAY;
               end
            end
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      logic [14:0] act, exp;
      logic [7:0]  tb;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
               if (k == 0)
                  act = {ifa.o_higher, ifa.o_lower, ifa.o_correct, ifa.o_invalid,
                         ifa.o_result_valid, ifa.o_game_over, ifa.o_tries, ifa.o_playing};
               else
                  act = {ifb.o_higher, ifb.o_lower, ifb.o_correct, ifb.o_invalid,
                         ifb.o_result_valid, ifb.o_game_over, ifb.o_tries, ifb.o_playing};
               tb  = {4'(m_tries[k] / 10), 4'(m_tries[k] % 10)};
               exp = {m_hi[k], m_lo[k], m_co[k], m_inv[k], m_rv[k], m_go[k], tb,
                      (m_phase[k] == P_PLAY || m_phase[k] == P_CHECK)};
               n_cmp++;
               if (act !== exp) begin
                  n_bad++;
                  $display("FAIL model_dut%0d t=%0t: got h/l/c/i/rv/go/tries/play=%b want %b",
                           k, $time, act, exp);
               end
               if (act[10] === 1'b1) rv_cnt[k]++;
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic do_guess(input logic [16:0] g);
      ifa.i_guess = g;
      ifa.i_submit_guess = 1'b0;
      step(2);
      ifa.i_submit_guess = 1'b1;
      step(5);
   endtask

   task automatic start_game(input logic [16:0] t);
      ifa.i_nvalue = t;
      ifa.i_new_game = 1'b1;
      step(1);
      ifa.i_new_game = 1'b0;
      ifa.i_nvalue = 17'h00007;
   endtask

   initial begin
      ifa.i_new_game = 1'b0;
      ifa.i_submit_guess = 1'b1;
      ifa.i_guess = 17'h0;
      ifa.i_nvalue = 17'h0;
      rst = 1'b1;
      step(1);
      chk_en = 1'b1;
      step(2);
      rst = 1'b0;
      check_lit("reset_tries", 32'(ifa.o_tries), 32'h00);
      check_lit("reset_playing", 32'(ifa.o_playing), 32'h0);

      // Button held with no game running: nothing happens.
      ifa.i_submit_guess = 1'b0;
      step(10);
      ifa.i_submit_guess = 1'b1;
      step(4);
      check_lit("idle_no_rv", 32'(rv_cnt[0]), 32'd0);
      check_lit("idle_tries", 32'(ifa.o_tries), 32'h00);
      check_lit("idle_playing", 32'(ifa.o_playing), 32'h0);

      // Main game: higher, lower, correct.
      start_game(17'h01234);
      check_lit("ng_playing", 32'(ifa.o_playing), 32'h1);
      do_guess(17'h00999);
      check_lit("g1_flags", 32'({ifa.o_higher, ifa.o_lower, ifa.o_correct, ifa.o_invalid}), 32'b1000);
      check_lit("g1_tries", 32'(ifa.o_tries), 32'h01);
      do_guess(17'h10000);
      check_lit("g2_flags", 32'({ifa.o_higher, ifa.o_lower, ifa.o_correct, ifa.o_invalid}), 32'b0100);
      check_lit("g2_tries", 32'(ifa.o_tries), 32'h02);
      do_guess(17'h01234);
      check_lit("g3_flags", 32'({ifa.o_higher, ifa.o_lower, ifa.o_correct, ifa.o_invalid}), 32'b0010);
      check_lit("g3_tries", 32'(ifa.o_tries), 32'h03);
      check_lit("g3_win_playing", 32'(ifa.o_playing), 32'h0);
      check_lit("g3_b_win_not_lose", 32'({ifb.o_correct, ifb.o_game_over}), 32'b10);
      do_guess(17'h01234);
      check_lit("win_press_ignored", 32'(rv_cnt[0]), 32'd3);

      // Invalid digit, then a valid guess clears it.
      start_game(17'h01234);
      do_guess(17'h012A4);
      check_lit("inv_flags", 32'({ifa.o_higher, ifa.o_lower, ifa.o_correct, ifa.o_invalid}), 32'b0001);
      check_lit("inv_tries", 32'(ifa.o_tries), 32'h00);
      check_lit("inv_playing", 32'(ifa.o_playing), 32'h1);
      do_guess(17'h00500);
      check_lit("post_inv_flags", 32'({ifa.o_higher, ifa.o_lower, ifa.o_correct, ifa.o_invalid}), 32'b1000);
      check_lit("post_inv_tries", 32'(ifa.o_tries), 32'h01);

      // Attempt limit: limit-3 instance loses on the 3rd, limit-10 on the 10th (BCD carry).
      start_game(17'h00005);
      repeat (3) do_guess(17'h00001);
      check_lit("b_lose_tries", 32'(ifb.o_tries), 32'h03);
      check_lit("b_lose_go", 32'({ifb.o_higher, ifb.o_game_over, ifb.o_playing}), 32'b110);
      check_lit("a_three_tries", 32'({ifa.o_game_over, ifa.o_tries}), 32'h003);
      repeat (7) do_guess(17'h00001);
      check_lit("a_lose_tries", 32'(ifa.o_tries), 32'h10);
      check_lit("a_lose_go", 32'({ifa.o_higher, ifa.o_game_over, ifa.o_playing}), 32'b110);
      check_lit("b_lose_frozen", 32'(ifb.o_tries), 32'h03);

      // Long hold counts once.
      start_game(17'h00005);
      rv_snap = rv_cnt[0];
      ifa.i_guess = 17'h00001;
      ifa.i_submit_guess = 1'b0;
      step(50);
      ifa.i_submit_guess = 1'b1;
      step(5);
      check_lit("hold_one_try", 32'(ifa.o_tries), 32'h01);
      check_lit("hold_one_rv", 32'(rv_cnt[0] - rv_snap), 32'd1);

      // new_game in the press cycle discards the press.
      rv_snap = rv_cnt[0];
      ifa.i_submit_guess = 1'b0;
      step(2);
      ifa.i_new_game = 1'b1;
      step(1);
      ifa.i_new_game = 1'b0;
      ifa.i_submit_guess = 1'b1;
      step(5);
      check_lit("ng_press_tries", 32'(ifa.o_tries), 32'h00);
      check_lit("ng_press_no_rv", 32'(rv_cnt[0] - rv_snap), 32'd0);
      check_lit("ng_press_playing", 32'(ifa.o_playing), 32'h1);

      // Reset during CHECK loses the result.
      rv_snap = rv_cnt[0];
      ifa.i_guess = 17'h00003;
      ifa.i_submit_guess = 1'b0;
      step(3);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      ifa.i_submit_guess = 1'b1;
      check_lit("rst_check_outs", 32'({ifa.o_higher, ifa.o_lower, ifa.o_correct, ifa.o_invalid,
                ifa.o_result_valid, ifa.o_game_over, ifa.o_tries, ifa.o_playing}), 32'h0);
      step(5);
      check_lit("rst_check_no_rv", 32'(rv_cnt[0] - rv_snap), 32'd0);
      check_lit("rst_check_idle", 32'({ifa.o_playing, ifa.o_tries}), 32'h000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
